// File: rtl/fir1_pkg.sv
// Shared types, coefficients and output rounding for the 11-tap half-band FIR.
// FIR1_SAT_EN selects saturation of the output; otherwise it wraps to 14 bits.
package fir1_pkg;

  localparam int DW    = 14;
  localparam int CW    = 16;
  localparam int NTAPS = 11;
  localparam int AW    = DW + CW + 4;
  localparam int FRAC  = CW - 1;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [DW:0]   preadd_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [AW-1:0] acc_t;

  localparam coef_t COEFF [NTAPS] = '{
    16'sd186, 16'sd0, -16'sd1528, 16'sd0, 16'sd9535, 16'sd16384,
    16'sd9535, 16'sd0, -16'sd1528, 16'sd0, 16'sd186
  };

  localparam sample_t SMAX = sample_t'((1 << (DW - 1)) - 1);
  localparam sample_t SMIN = sample_t'(-(1 << (DW - 1)));

  // Round half up at the Q1.15 binary point, then clamp or wrap to DW bits.
  function automatic sample_t sat_round(input acc_t acc);
    acc_t    rnd;
    sample_t res;
    rnd = (acc + (acc_t'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef FIR1_SAT_EN
    if (rnd > acc_t'(SMAX)) begin
      res = SMAX;
    end else if (rnd < acc_t'(SMIN)) begin
      res = SMIN;
    end else begin
      res = sample_t'(rnd);
    end
`else
    res = sample_t'(rnd);
`endif
    return res;
  endfunction

endpackage

// File: rtl/fir1_filter_tap_mac.sv
// Symmetric pre-adder followed by a constant-coefficient multiply.
module fir1_tap_mac
  import fir1_pkg::*;
#(
  parameter coef_t COEF = '0
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] prod
);

  preadd_t pre;

  always_comb begin
    pre  = preadd_t'(a) + preadd_t'(b);
    prod = acc_t'(pre) * acc_t'(COEF);
  end

endmodule

// File: rtl/fir1_filter.sv
// 11-tap symmetric half-band FIR: delay line, folded taps, adder tree and
// registered rounded output. Define FIR1_SAT_EN for output saturation.
module fir1_filter
  import fir1_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] X,
  output logic signed [DW-1:0] Y
);

  localparam int NPAIR = NTAPS / 2 + 1;

  sample_t d_q [1:NTAPS-1];
  sample_t d_d [1:NTAPS-1];
  sample_t tap [NTAPS];
  acc_t    prod [NPAIR];
  acc_t    acc;
  sample_t y_d, y_q;

  always_comb begin
    tap[0] = X;
    for (int unsigned k = 1; k < NTAPS; k++) begin
      tap[k] = d_q[k];
    end
  end

  // Fold tap k with tap NTAPS-1-k; the centre tap has no partner and zero
  // coefficients produce no hardware.
  generate
    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
      if (COEFF[p] == '0) begin : g_zero
        assign prod[p] = '0;
      end else if (p == NTAPS - 1 - p) begin : g_center
        fir1_tap_mac #(.COEF(COEFF[p])) u_mac (
          .a    (tap[p]),
          .b    ('0),
          .prod (prod[p])
        );
      end else begin : g_sym
        fir1_tap_mac #(.COEF(COEFF[p])) u_mac (
          .a    (tap[p]),
          .b    (tap[NTAPS-1-p]),
          .prod (prod[p])
        );
      end
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int unsigned p = 0; p < NPAIR; p++) begin
      acc = acc + prod[p];
    end
    y_d = sat_round(acc);
    d_d[1] = X;
    for (int unsigned k = 2; k < NTAPS; k++) begin
      d_d[k] = d_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
      for (int unsigned k = 1; k < NTAPS; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      y_q <= y_d;
      d_q <= d_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_fir1_filter.sv
// Scoreboard bench for fir1_filter: stimulus pushes expected outputs, a monitor
// pops and compares one value per clock after each rising edge.
module tb_fir1_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [13:0] X;
  logic signed [13:0] Y;

  fir1_filter dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  always #5 clk = ~clk;

  int    exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  int H [11] = '{186, 0, -1528, 0, 9535, 16384, 9535, 0, -1528, 0, 186};
  int hist [11];

  int IMP  [12] = '{6, 0, -47, 0, 291, 500, 291, 0, -47, 0, 6, 0};
  int STEP [14] = '{23, 23, -168, -168, 1024, 3072, 4264, 4264,
                    4073, 4073, 4096, 4096, 4096, 4096};
  int WC   [11] = '{8191, 0, -8192, 0, 8191, 8191, 8191, 0, -8192, 0, 8191};
`ifdef FIR1_SAT_EN
  int WC_EXP = 8191;
`else
  int WC_EXP = -6665;
`endif

  int    mon_e;
  string mon_n;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        n_cmp++;
        if (int'(Y) !== mon_e) begin
          n_bad++;
          $display("FAIL %s: Y=%0d expected %0d", mon_n, Y, mon_e);
        end
      end
    end
  end

  task automatic model_step(input bit rst, input int x, output int y);
    longint acc;
    longint r;
    logic signed [13:0] w;
    if (rst) begin
      for (int k = 0; k < 11; k++) hist[k] = 0;
      y = 0;
      return;
    end
    acc = longint'(H[0]) * x;
    for (int k = 1; k < 11; k++) acc += longint'(H[k]) * hist[k];
    r = (acc + 16384) >>> 15;
`ifdef FIR1_SAT_EN
    if (r > 8191) y = 8191;
    else if (r < -8192) y = -8192;
    else y = int'(r);
`else
    w = 14'(r);
    y = int'(w);
`endif
    for (int k = 10; k >= 2; k--) hist[k] = hist[k-1];
    hist[1] = x;
  endtask

  // mode: 0 = no check, 1 = hand value y_hand, 2 = golden model
  task automatic step(input bit rst, input int x, input int mode,
                      input int y_hand, input string nm);
    int m;
    @(negedge clk);
    reset = rst;
    X     = 14'(x);
    model_step(rst, x, m);
    if (mode == 1) begin
      exp_q.push_back(y_hand);
      name_q.push_back(nm);
    end else if (mode == 2) begin
      exp_q.push_back(m);
      name_q.push_back(nm);
    end
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation did not end, time=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    reset = 1'b1;
    X     = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1234, 1, 0, $sformatf("reset_init[%0d]", i));

    for (int i = 0; i < 14; i++) step(1'b0, 4096, 1, STEP[i], $sformatf("step[%0d]", i));

    for (int i = 0; i < 3; i++) step(1'b1, 1234, 1, 0, $sformatf("reset_hold[%0d]", i));

    for (int i = 0; i < 12; i++)
      step(1'b0, (i == 0) ? 1000 : 0, 1, IMP[i], $sformatf("impulse[%0d]", i));

    for (int i = 0; i < 11; i++)
      step(1'b0, WC[i], (i == 10) ? 1 : 0, WC_EXP, "worst_case");

    for (int i = 0; i < 20; i++)
      step(1'b0, int'($urandom_range(16383, 0)) - 8192, 2, 0, $sformatf("rand_pre[%0d]", i));
    step(1'b1, 5555, 1, 0, "mid_reset");
    for (int i = 0; i < 46; i++)
      step(1'b0, int'($urandom_range(16383, 0)) - 8192, 2, 0, $sformatf("rand[%0d]", i));
    step(1'b0, 0, 2, 0, "rand_tail");

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
